// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the Wishbone master bridge and its peers.
//   - wb_state_e    : bridge FSM state encoding (IDLE / BUS / RESP)
//   - *_W_DEF       : default bus widths (data 32, address 32, select 4)
//   - WB_WORD_IDX_* : byte-address bits [4:2] pick one of eight 32-bit registers
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int WB_DATA_W_DEF = 32;
  localparam int WB_ADDR_W_DEF = 32;
  localparam int WB_SEL_W_DEF  = 4;

  // Register index within a responder: addr[WB_WORD_IDX_MSB:WB_WORD_IDX_LSB]
  localparam int WB_WORD_IDX_LSB = 2;
  localparam int WB_WORD_IDX_MSB = 4;

endpackage

// File: rtl/wb_bus_watchdog.sv
// wb_bus_watchdog: counts cycles a bus cycle has been waiting for ack.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clear_i   : restart the count (new cycle launched)
//   en_i      : count this cycle (cycle open, no ack seen)
//   expired_o : count has reached TIMEOUT_CYCLES-1
// The counter saturates at TIMEOUT_CYCLES-1 and never wraps.
module wb_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                   cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-outstanding Wishbone classic initiator.
// Converts a valid/ready request port into one bus cycle at a time and
// returns read data (or 0 for writes/errors) on a valid/ready response port.
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   req_valid_i/req_ready_o          : request handshake
//   req_addr_i/req_data_i/req_we_i/req_sel_i : request fields
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_data_o, rsp_err_o            : read data, timeout error flag
//   wb_addr_o/wb_data_o/wb_sel_o/wb_we_o : registered bus fields
//   wb_cyc_o/wb_stb_o                : cycle/strobe (always equal)
//   wb_ack_i, wb_data_i              : responder acknowledge and read data
// Optional feature macro: WB_MASTER_TIMEOUT_EN enables the bus watchdog that
// aborts a cycle after TIMEOUT_CYCLES without ack (rsp_err_o=1). Without it
// the bridge waits forever for ack and rsp_err_o is tied 0.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DATA_W_DEF,
  parameter int WB_ADDR_WIDTH  = WB_ADDR_W_DEF,
  parameter int WB_SEL_WIDTH   = WB_SEL_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_data_i,
  input  logic                     req_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  req_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_master_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  wb_state_e                state_q;
  logic                     req_ready_q;
  logic                     rsp_valid_q;
  logic [WB_DATA_WIDTH-1:0] rsp_data_q;
  logic [WB_ADDR_WIDTH-1:0] wb_addr_q;
  logic [WB_DATA_WIDTH-1:0] wb_data_q;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_q;
  logic                     wb_we_q;
  logic                     wb_cyc_q;

  // req_ready_q is held low for the first cycle out of reset, so a request is
  // only taken once the registered ready has actually been presented.
  logic accept;
  assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid_i;

`ifdef WB_MASTER_TIMEOUT_EN
  logic rsp_err_q;
  logic wd_expired;
  logic timeout;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (accept),
    .en_i      ((state_q == ST_BUS) && !wb_ack_i),
    .expired_o (wd_expired)
  );

  // ack in the expiry cycle takes priority (see BUS branch ordering).
  assign timeout   = (state_q == ST_BUS) && !wb_ack_i && wd_expired;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_sel_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            wb_addr_q   <= req_addr_i;
            wb_data_q   <= req_data_i;
            wb_sel_q    <= req_sel_i;
            wb_we_q     <= req_we_i;
            wb_cyc_q    <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_q    <= 1'b0;
            rsp_data_q  <= wb_we_q ? '0 : wb_data_i;
            rsp_valid_q <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= ST_RESP;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (timeout) begin
            wb_cyc_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          // Ready rises only in the following IDLE cycle, so the consume
          // cycle can never also accept a request.
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          wb_cyc_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_we_o     = wb_we_q;
  assign wb_cyc_o    = wb_cyc_q;
  assign wb_stb_o    = wb_cyc_q;

endmodule
